count_arbiter: RTL and testbench



---
 rtl/count_arbiter_if.sv | 31 +++
 rtl/count_arbiter.sv | 141 ++++++++++++++
 tb/tb_count_arbiter.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/count_arbiter_if.sv
// Bus between the requesters and the shared-counter arbiter.
// Latency: none, this is wiring only.
// Backpressure: none here. The arbiter holds off other requesters until the granted one releases.
interface count_arbiter_if #(
    parameter int N_REQ = 2,
    parameter int WIDTH = 3
);
    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] dir;
    logic [N_REQ-1:0] gnt;
    logic             busy;
    logic [WIDTH-1:0] count;

    // Requester side: drives requests and directions, observes grants and the count.
    modport master (
        output req,
        output dir,
        input  gnt,
        input  busy,
        input  count
    );

    // Arbiter side: owns the grant, the busy flag and the shared count.
    modport slave (
        input  req,
        input  dir,
        output gnt,
        output busy,
        output count
    );
endinterface

// File: rtl/count_arbiter.sv
// Round-robin arbiter that applies one +/-1 step to a shared counter per granted request.
// Latency: the gnt pulse appears the cycle after req is sampled in IDLE, and count updates at the edge closing that pulse.
// Backpressure: one step per req assertion. Other requesters stay pending until the granted one drops req.
module count_arbiter #(
    parameter int N_REQ = 2,
    parameter int WIDTH = 3
) (
    input  logic           clk,
    input  logic           reset,
    count_arbiter_if.slave bus
);
    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] STEP    = 2'd1;
    localparam logic [1:0] RELEASE = 2'd2;

    // After reset the pointer sits on the top requester, so requester 0 wins the first decision.
    localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(N_REQ - 1);

    logic [1:0]       state;
    logic [1:0]       next_state;
    logic [IDX_W-1:0] sel;
    logic             sel_dir;
    logic [IDX_W-1:0] last;
    logic [N_REQ-1:0] gnt_q;
    logic             busy_q;
    logic [WIDTH-1:0] count_q;

    logic             any_req;
    logic             hi_hit;
    logic [IDX_W-1:0] hi_sel;
    logic [IDX_W-1:0] lo_sel;
    logic [IDX_W-1:0] rr_sel;
    logic [N_REQ-1:0] rr_onehot;
    logic             release_done;

    assign any_req      = |bus.req;
    assign release_done = !bus.req[sel];

    // Round-robin pick. Prefer the lowest active index above last, otherwise wrap to the lowest active index.
    // The loop runs downward so the final assignment is the lowest qualifying index.
    always_comb begin
        hi_hit = 1'b0;
        hi_sel = '0;
        lo_sel = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (bus.req[i]) begin
                lo_sel = IDX_W'(i);
                if (IDX_W'(i) > last) begin
                    hi_sel = IDX_W'(i);
                    hi_hit = 1'b1;
                end
            end
        end
        rr_sel = hi_hit ? hi_sel : lo_sel;
    end

    // One-hot form of the winner, loaded straight into the grant register.
    always_comb begin
        rr_onehot = '0;
        for (int i = 0; i < N_REQ; i++) begin
            rr_onehot[i] = (rr_sel == IDX_W'(i));
        end
    end

    // Next-state logic. STEP always lasts one cycle. RELEASE waits for the served requester to let go.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (any_req) next_state = STEP;
            STEP:    next_state = RELEASE;
            RELEASE: if (release_done) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Latch the winner and its direction at the decision.
    // Later changes to dir or req cannot alter the step in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sel     <= '0;
            sel_dir <= 1'b0;
        end else if (state == IDLE && any_req) begin
            sel     <= rr_sel;
            sel_dir <= bus.dir[rr_sel];
        end
    end

    // Advance the fairness pointer when the step completes, so the requester just served drops to lowest priority.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last <= LAST_RST;
        end else if (state == STEP) begin
            last <= sel;
        end
    end

    // Shared counter. Modulo 2^WIDTH in both directions, with no saturation.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else if (state == STEP) begin
            count_q <= sel_dir ? count_q + WIDTH'(1) : count_q - WIDTH'(1);
        end
    end

    // Registered grant. High only during the STEP cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gnt_q <= '0;
        end else if (state == IDLE && any_req) begin
            gnt_q <= rr_onehot;
        end else begin
            gnt_q <= '0;
        end
    end

    // Registered busy. Tracks "FSM not in IDLE" with no combinational path from the inputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_q <= 1'b0;
        end else begin
            busy_q <= (next_state != IDLE);
        end
    end

    assign bus.gnt   = gnt_q;
    assign bus.busy  = busy_q;
    assign bus.count = count_q;

endmodule

// File: tb/tb_count_arbiter.sv
// Directed bench for count_arbiter with three requesters and a 3-bit count.
// Expected grants and counts are queued when stimulus is driven and checked when a grant appears.
module tb_count_arbiter;
    localparam int N = 3;
    localparam int W = 3;

    typedef struct {
        logic [N-1:0] g;
        logic [W-1:0] c;
    } exp_t;

    logic clk;
    logic reset;

    count_arbiter_if #(.N_REQ(N), .WIDTH(W)) bus ();

    count_arbiter #(.N_REQ(N), .WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int           checks = 0;
    int           errors = 0;
    int           cyc = 0;
    int           last_gnt_cyc = -1;
    exp_t         sb[$];
    exp_t         e;
    logic         cnt_pending = 1'b0;
    logic [W-1:0] cnt_exp;
    logic [W-1:0] m_count;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Global watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog simulation did not reach the end");
        $fatal(1);
    end

    // Monitor: pop an expectation on every grant, then check the count one cycle later.
    always @(negedge clk) begin
        cyc++;
        if (cnt_pending) begin
            checks++;
            assert (bus.count === cnt_exp) else begin
                errors++;
                $error("FAIL step_count observed=%0d expected=%0d", bus.count, cnt_exp);
            end
            cnt_pending = 1'b0;
        end
        if (bus.gnt !== '0) begin
            checks++;
            assert (sb.size() != 0) else begin
                errors++;
                $error("FAIL unexpected_gnt observed=%b expected=none", bus.gnt);
            end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                checks++;
                assert (bus.gnt === e.g) else begin
                    errors++;
                    $error("FAIL gnt_order observed=%b expected=%b", bus.gnt, e.g);
                end
                cnt_exp     = e.c;
                cnt_pending = 1'b1;
            end
            checks++;
            assert (bus.busy === 1'b1) else begin
                errors++;
                $error("FAIL busy_in_step observed=%b expected=1", bus.busy);
            end
            if (last_gnt_cyc >= 0) begin
                checks++;
                assert (cyc - last_gnt_cyc >= 3) else begin
                    errors++;
                    $error("FAIL gnt_spacing observed=%0d expected>=3", cyc - last_gnt_cyc);
                end
            end
            last_gnt_cyc = cyc;
        end
    end

    task automatic check_idle_outputs(input string tag);
        checks++;
        assert (bus.count === '0) else begin
            errors++;
            $error("FAIL %s count observed=%0d expected=0", tag, bus.count);
        end
        checks++;
        assert (bus.gnt === '0) else begin
            errors++;
            $error("FAIL %s gnt observed=%b expected=000", tag, bus.gnt);
        end
        checks++;
        assert (bus.busy === 1'b0) else begin
            errors++;
            $error("FAIL %s busy observed=%b expected=0", tag, bus.busy);
        end
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (bus.busy !== 1'b0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        assert (bus.busy === 1'b0) else begin
            errors++;
            $error("FAIL %s wait_idle busy observed=%b expected=0", tag, bus.busy);
        end
    endtask

    task automatic wait_gnt(input int i, input string tag);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.gnt[i] !== 1'b1 && n < 20);
        checks++;
        assert (bus.gnt[i] === 1'b1) else begin
            errors++;
            $error("FAIL %s gnt[%0d] observed=%b expected=1", tag, i, bus.gnt[i]);
        end
    endtask

    // Single press from requester i, called at a negedge with the DUT idle. Requires hold >= 2.
    task automatic press(input int i, input logic up, input int hold, input string tag);
        logic [N-1:0] oh;
        oh = '0;
        oh[i] = 1'b1;
        bus.req[i] = 1'b1;
        bus.dir[i] = up;
        m_count = up ? m_count + 3'd1 : m_count - 3'd1;
        sb.push_back('{g: oh, c: m_count});
        @(negedge clk);
        checks++;
        assert (bus.gnt === oh) else begin
            errors++;
            $error("FAIL %s gnt_latency observed=%b expected=%b", tag, bus.gnt, oh);
        end
        repeat (hold - 1) @(negedge clk);
        checks++;
        assert (bus.busy === 1'b1) else begin
            errors++;
            $error("FAIL %s busy_hold observed=%b expected=1", tag, bus.busy);
        end
        bus.req[i] = 1'b0;
        @(negedge clk);
        checks++;
        assert (bus.busy === 1'b0) else begin
            errors++;
            $error("FAIL %s busy_fall observed=%b expected=0", tag, bus.busy);
        end
    endtask

    initial begin
        reset   = 1'b1;
        bus.req = '0;
        bus.dir = '0;
        m_count = '0;
        #3;
        check_idle_outputs("reset_init");
        @(negedge clk);
        reset = 1'b0;

        // Single up step held for 6 cycles: one grant, count goes 0 -> 1.
        press(0, 1'b1, 6, "single_up");

        // Down through zero (0 -> 7), then up through all-ones (7 -> 0), then down again (0 -> 7).
        press(0, 1'b0, 2, "down_1_0");
        press(0, 1'b0, 2, "wrap_down");
        press(0, 1'b1, 3, "wrap_up");
        press(0, 1'b0, 3, "wrap_down2");
        press(0, 1'b0, 2, "down_7_6");

        // Reach count=5 with the FSM in RELEASE, then hit reset mid-cycle.
        bus.req[0] = 1'b1;
        bus.dir[0] = 1'b0;
        m_count = m_count - 3'd1;
        sb.push_back('{g: 3'b001, c: m_count});
        repeat (3) @(negedge clk);
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check_idle_outputs("reset_mid");
        bus.req = '0;
        @(negedge clk);
        reset = 1'b0;
        m_count = '0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check_idle_outputs("idle_hold");
        end

        // Simultaneous requests out of reset: 0 goes down first, then 1 goes up.
        bus.dir = 3'b010;
        bus.req = 3'b011;
        sb.push_back('{g: 3'b001, c: 3'd7});
        sb.push_back('{g: 3'b010, c: 3'd0});
        wait_gnt(0, "simul_g0");
        repeat (2) @(negedge clk);
        bus.req[0] = 1'b0;
        wait_gnt(1, "simul_g1");
        repeat (2) @(negedge clk);
        bus.req[1] = 1'b0;
        wait_idle("simul_end");

        // Fairness: reset the pointer, then pulse all requests one cycle after each return to IDLE.
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        m_count = '0;
        bus.dir = 3'b111;
        for (int k = 0; k < 6; k++) begin
            logic [N-1:0] oh;
            oh = '0;
            oh[k % N] = 1'b1;
            m_count = m_count + 3'd1;
            sb.push_back('{g: oh, c: m_count});
        end
        for (int k = 0; k < 6; k++) begin
            wait_idle("rr_wait");
            bus.req = 3'b111;
            @(negedge clk);
            bus.req = 3'b000;
        end
        wait_idle("rr_end");

        // Flip dir while gnt is high: the latched direction still gives +1.
        bus.dir = 3'b001;
        bus.req = 3'b001;
        m_count = m_count + 3'd1;
        sb.push_back('{g: 3'b001, c: m_count});
        wait_gnt(0, "dir_flip");
        bus.dir = 3'b000;
        repeat (2) @(negedge clk);
        bus.req = 3'b000;
        wait_idle("dir_flip_end");

        repeat (3) @(negedge clk);
        checks++;
        assert (sb.size() == 0) else begin
            errors++;
            $error("FAIL scoreboard_drain observed=%0d expected=0", sb.size());
        end
        checks++;
        assert (cnt_pending === 1'b0) else begin
            errors++;
            $error("FAIL count_pending observed=%b expected=0", cnt_pending);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
